// File: rtl/rf_wb_arbiter_if.sv
// Write-back bus between the execute/memory requesters, decode and the
// register-file write-back arbiter.
//   req_valid/req_addr/req_data/req_ready : round-robin valid/ready write-back requests
//   rf_wen/rf_waddr/rf_wdata              : registered RegisterFile write port
//   sb_set/sb_set_addr/sb_set_ready       : decode reserves a destination register
//   chk_rs1/chk_rs2/hazard                : decode read-after-write hazard query
//   sb_err                                : sticky scoreboard underflow flag
// Modports: master = requesters/decode side, slave = arbiter.
interface rf_wb_arbiter_if #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned REG_NUM_BIT = 5,
    parameter int unsigned NUM_REQ     = 3
);
    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ*REG_NUM_BIT-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0]  req_data;
    logic [NUM_REQ-1:0]             req_ready;
    logic                           rf_wen;
    logic [REG_NUM_BIT-1:0]         rf_waddr;
    logic [DATA_WIDTH-1:0]          rf_wdata;
    logic                           sb_set;
    logic [REG_NUM_BIT-1:0]         sb_set_addr;
    logic                           sb_set_ready;
    logic [REG_NUM_BIT-1:0]         chk_rs1;
    logic [REG_NUM_BIT-1:0]         chk_rs2;
    logic                           hazard;
    logic                           sb_err;

    modport master (
        output req_valid, req_addr, req_data, sb_set, sb_set_addr, chk_rs1, chk_rs2,
        input  req_ready, rf_wen, rf_waddr, rf_wdata, sb_set_ready, hazard, sb_err
    );

    modport slave (
        input  req_valid, req_addr, req_data, sb_set, sb_set_addr, chk_rs1, chk_rs2,
        output req_ready, rf_wen, rf_waddr, rf_wdata, sb_set_ready, hazard, sb_err
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Register-file write-back arbiter with pending-write scoreboard.
// Shares the single RegisterFile write port among NUM_REQ requesters (0 = ALU,
// 1 = LSU, 2 = CSR) using round-robin arbitration, registers the winning write
// onto rf_wen/rf_waddr/rf_wdata, and keeps a per-register count of reserved but
// not yet committed writes so decode can detect read-after-write hazards.
// Ports:
//   clk  : clock, all state on posedge
//   rst  : synchronous active-high reset
//   bus  : rf_wb_arbiter_if slave modport (requests, write port, scoreboard)
module rf_wb_arbiter #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned REG_NUM     = 32,
    parameter int unsigned REG_NUM_BIT = 5,
    parameter int unsigned NUM_REQ     = 3,
    parameter int unsigned CNT_W       = 2
) (
    input  logic          clk,
    input  logic          rst,
    rf_wb_arbiter_if.slave bus
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Unpacked views of the flattened request buses
    logic [REG_NUM_BIT-1:0] req_addr_a [NUM_REQ];
    logic [DATA_WIDTH-1:0]  req_data_a [NUM_REQ];

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_addr_a[i] = bus.req_addr[i*REG_NUM_BIT +: REG_NUM_BIT];
            req_data_a[i] = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // State
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic                   rf_wen_q, rf_wen_d;
    logic [REG_NUM_BIT-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_WIDTH-1:0]  rf_wdata_q, rf_wdata_d;
    logic [CNT_W-1:0]       cnt_q [REG_NUM];
    logic [CNT_W-1:0]       cnt_d [REG_NUM];
    logic                   sb_err_q, sb_err_d;

    // Round-robin arbitration: scan from the requester after the last winner
    logic [NUM_REQ-1:0]     grant;
    logic                   grant_vld;
    logic [PTR_W-1:0]       grant_idx;
    logic [PTR_W-1:0]       scan_idx;
    logic [REG_NUM_BIT-1:0] sel_addr;
    logic [DATA_WIDTH-1:0]  sel_data;

    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        sel_addr  = '0;
        sel_data  = '0;
        if (!rst) begin
            for (int unsigned k = 1; k <= NUM_REQ; k++) begin
                scan_idx = PTR_W'((32'(ptr_q) + k) % NUM_REQ);
                if (!grant_vld && bus.req_valid[scan_idx]) begin
                    grant_vld       = 1'b1;
                    grant_idx       = scan_idx;
                    grant[scan_idx] = 1'b1;
                    sel_addr        = req_addr_a[scan_idx];
                    sel_data        = req_data_a[scan_idx];
                end
            end
        end
    end

    // Write port next state; x0 transfers are consumed but never written
    always_comb begin
        ptr_d      = grant_vld ? grant_idx : ptr_q;
        rf_wen_d   = grant_vld && (sel_addr != '0);
        rf_waddr_d = grant_vld ? sel_addr : rf_waddr_q;
        rf_wdata_d = grant_vld ? sel_data : rf_wdata_q;
    end

    // Scoreboard: one-hot reserve and retire hits per register
    logic                 set_ok;
    logic [REG_NUM-1:0]   set_hit;
    logic [REG_NUM-1:0]   ret_hit;

    assign set_ok = bus.sb_set && bus.sb_set_ready && (bus.sb_set_addr != '0);

    always_comb begin
        set_hit = '0;
        ret_hit = '0;
        if (set_ok) begin
            set_hit[bus.sb_set_addr] = 1'b1;
        end
        if (rf_wen_q) begin
            ret_hit[rf_waddr_q] = 1'b1;
        end
    end

    always_comb begin
        sb_err_d = sb_err_q;
        for (int r = 0; r < REG_NUM; r++) begin
            cnt_d[r] = cnt_q[r];
            if (r == 0) begin
                cnt_d[r] = '0;
            end else if (set_hit[r] && !ret_hit[r]) begin
                cnt_d[r] = cnt_q[r] + CNT_W'(1);
            end else if (ret_hit[r] && !set_hit[r]) begin
                // Retiring a write nobody reserved: hold at zero and flag it
                if (cnt_q[r] == '0) begin
                    sb_err_d = 1'b1;
                end else begin
                    cnt_d[r] = cnt_q[r] - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= PTR_W'(NUM_REQ - 1);
            rf_wen_q   <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            sb_err_q   <= 1'b0;
            for (int r = 0; r < REG_NUM; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            ptr_q      <= ptr_d;
            rf_wen_q   <= rf_wen_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            sb_err_q   <= sb_err_d;
            for (int r = 0; r < REG_NUM; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    // Outputs
    assign bus.req_ready    = grant;
    assign bus.rf_wen       = rf_wen_q;
    assign bus.rf_waddr     = rf_waddr_q;
    assign bus.rf_wdata     = rf_wdata_q;
    assign bus.sb_err       = sb_err_q;
    assign bus.sb_set_ready = (cnt_q[bus.sb_set_addr] != CNT_MAX) || (bus.sb_set_addr == '0);
    assign bus.hazard       = ((bus.chk_rs1 != '0) && (cnt_q[bus.chk_rs1] != '0)) ||
                              ((bus.chk_rs2 != '0) && (cnt_q[bus.chk_rs2] != '0));

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed stimulus with literal expectations plus a
// behavioural model checked against the DUT on every falling edge.
module tb_rf_wb_arbiter;

    localparam int DW   = 32;
    localparam int RB   = 5;
    localparam int NR   = 3;
    localparam int RN   = 32;
    localparam int CMAX = 3;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    rf_wb_arbiter_if #(.DATA_WIDTH(DW), .REG_NUM_BIT(RB), .NUM_REQ(NR)) bus ();

    rf_wb_arbiter #(
        .DATA_WIDTH (DW),
        .REG_NUM    (RN),
        .REG_NUM_BIT(RB),
        .NUM_REQ    (NR),
        .CNT_W      (2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_last;      // index of the last requester served
    bit          m_wen;
    bit [RB-1:0] m_waddr;
    bit [DW-1:0] m_wdata;
    bit          m_ad_known;  // addr/data value is defined (not after an x0 transfer)
    int          m_cnt [RN];
    bit          m_err;
    bit          m_live = 1'b0;

    int          g;
    int          c_set;
    int          c_ret;
    logic [NR-1:0] exp_rdy;
    bit          exp_haz;
    bit          exp_sbr;

    always @(negedge clk) begin
        g = -1;
        if (!rst) begin
            for (int k = 1; k <= NR; k++) begin
                if (g < 0 && bus.req_valid[(m_last + k) % NR]) g = (m_last + k) % NR;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        exp_haz = (bus.chk_rs1 != 0 && m_cnt[bus.chk_rs1] > 0) ||
                  (bus.chk_rs2 != 0 && m_cnt[bus.chk_rs2] > 0);
        exp_sbr = (bus.sb_set_addr == 0) || (m_cnt[bus.sb_set_addr] < CMAX);

        if (m_live) begin
            check("m_req_ready", 64'(bus.req_ready), 64'(exp_rdy));
            check("m_rf_wen", 64'(bus.rf_wen), 64'(m_wen));
            if (m_ad_known) begin
                check("m_rf_waddr", 64'(bus.rf_waddr), 64'(m_waddr));
                check("m_rf_wdata", 64'(bus.rf_wdata), 64'(m_wdata));
            end
            check("m_hazard", 64'(bus.hazard), 64'(exp_haz));
            check("m_sb_set_ready", 64'(bus.sb_set_ready), 64'(exp_sbr));
            check("m_sb_err", 64'(bus.sb_err), 64'(m_err));
        end

        // advance to the state after the coming rising edge
        if (rst) begin
            m_last     = NR - 1;
            m_wen      = 1'b0;
            m_waddr    = '0;
            m_wdata    = '0;
            m_ad_known = 1'b1;
            m_err      = 1'b0;
            for (int r = 0; r < RN; r++) m_cnt[r] = 0;
            m_live     = 1'b1;
        end else begin
            c_set = (bus.sb_set && exp_sbr && bus.sb_set_addr != 0) ? int'(bus.sb_set_addr) : -1;
            c_ret = m_wen ? int'(m_waddr) : -1;
            if (!(c_ret >= 0 && c_ret == c_set)) begin
                if (c_set >= 0) m_cnt[c_set] = m_cnt[c_set] + 1;
                if (c_ret >= 0) begin
                    if (m_cnt[c_ret] == 0) m_err = 1'b1;
                    else m_cnt[c_ret] = m_cnt[c_ret] - 1;
                end
            end
            if (g >= 0) begin
                m_last     = g;
                m_waddr    = bus.req_addr[g*RB +: RB];
                m_wdata    = bus.req_data[g*DW +: DW];
                m_wen      = (m_waddr != 0);
                m_ad_known = m_wen;
            end else begin
                m_wen = 1'b0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input bit v, input logic [RB-1:0] a,
                           input logic [DW-1:0] d);
        bus.req_valid[i]         = v;
        bus.req_addr[i*RB +: RB] = a;
        bus.req_data[i*DW +: DW] = d;
    endtask

    initial begin
        rst             = 1'b1;
        bus.req_valid   = '0;
        bus.req_addr    = '0;
        bus.req_data    = '0;
        bus.sb_set      = 1'b0;
        bus.sb_set_addr = '0;
        bus.chk_rs1     = '0;
        bus.chk_rs2     = '0;
        tick();
        tick();

        // Reset state, with requests present that must not be granted
        bus.req_valid = 3'b111;
        look();
        check("rst_ready", 64'(bus.req_ready), 64'd0);
        check("rst_wen", 64'(bus.rf_wen), 64'd0);
        check("rst_waddr", 64'(bus.rf_waddr), 64'd0);
        check("rst_wdata", 64'(bus.rf_wdata), 64'd0);
        check("rst_err", 64'(bus.sb_err), 64'd0);
        bus.req_valid = '0;
        tick();
        rst = 1'b0;

        // Reserve x1..x3 twice each for the round-robin burst
        for (int r = 1; r <= 3; r++) begin
            for (int n = 0; n < 2; n++) begin
                bus.sb_set      = 1'b1;
                bus.sb_set_addr = RB'(r);
                look();
                check("resv_ready", 64'(bus.sb_set_ready), 64'd1);
                tick();
            end
        end
        bus.sb_set  = 1'b0;
        bus.chk_rs1 = 5'd1;
        bus.chk_rs2 = 5'd3;

        // 1: all requesters valid -> grants 0,1,2,0,1,2
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, RB'(i + 1), 32'hA000_0000 + 32'(i));
        for (int i = 0; i < 6; i++) begin
            look();
            check("t1_grant", 64'(bus.req_ready), 64'(1 << (i % 3)));
            if (i > 0) check("t1_waddr", 64'(bus.rf_waddr), 64'((i - 1) % 3 + 1));
            tick();
        end
        bus.req_valid = '0;
        look();
        check("t1_last_wen", 64'(bus.rf_wen), 64'd1);
        check("t1_last_waddr", 64'(bus.rf_waddr), 64'd3);
        check("t1_last_wdata", 64'(bus.rf_wdata), 64'hA000_0002);
        tick();

        // 2: lone LSU write
        bus.sb_set      = 1'b1;
        bus.sb_set_addr = 5'd5;
        set_req(1, 1'b1, 5'd5, 32'hDEAD_BEEF);
        look();
        check("t2_ready", 64'(bus.req_ready), 64'b010);
        tick();
        bus.sb_set    = 1'b0;
        bus.req_valid = '0;
        look();
        check("t2_wen", 64'(bus.rf_wen), 64'd1);
        check("t2_waddr", 64'(bus.rf_waddr), 64'd5);
        check("t2_wdata", 64'(bus.rf_wdata), 64'hDEAD_BEEF);
        tick();
        look();
        check("t2_idle_wen", 64'(bus.rf_wen), 64'd0);
        check("t2_hold_waddr", 64'(bus.rf_waddr), 64'd5);
        tick();

        // 3: saturate x7, then drain it through the CSR requester
        bus.chk_rs1 = 5'd7;
        bus.chk_rs2 = 5'd0;
        for (int n = 0; n < 3; n++) begin
            bus.sb_set      = 1'b1;
            bus.sb_set_addr = 5'd7;
            look();
            check("t3_set_ready", 64'(bus.sb_set_ready), 64'd1);
            tick();
        end
        look();
        check("t3_full_ready", 64'(bus.sb_set_ready), 64'd0);
        check("t3_hazard", 64'(bus.hazard), 64'd1);
        tick();
        bus.sb_set = 1'b0;
        for (int n = 0; n < 3; n++) begin
            set_req(2, 1'b1, 5'd7, 32'(n + 1));
            look();
            check("t3_grant", 64'(bus.req_ready), 64'b100);
            tick();
        end
        bus.req_valid = '0;
        look();
        check("t3_third_wen", 64'(bus.rf_wen), 64'd1);
        check("t3_third_wdata", 64'(bus.rf_wdata), 64'd3);
        check("t3_haz_at_last", 64'(bus.hazard), 64'd1);
        tick();
        look();
        check("t3_haz_clear", 64'(bus.hazard), 64'd0);
        tick();

        // 4: x0 write and x0 reservation
        bus.chk_rs1     = 5'd0;
        bus.sb_set      = 1'b1;
        bus.sb_set_addr = 5'd0;
        set_req(0, 1'b1, 5'd0, 32'h55);
        look();
        check("t4_grant", 64'(bus.req_ready), 64'b001);
        check("t4_set_ready", 64'(bus.sb_set_ready), 64'd1);
        check("t4_hazard", 64'(bus.hazard), 64'd0);
        tick();
        bus.req_valid = '0;
        look();
        check("t4_no_wen", 64'(bus.rf_wen), 64'd0);
        check("t4_hazard2", 64'(bus.hazard), 64'd0);
        tick();

        // 5: reserve and retire x9 in the same cycle
        bus.sb_set_addr = 5'd9;
        look();
        tick();
        bus.sb_set  = 1'b0;
        bus.chk_rs2 = 5'd9;
        set_req(1, 1'b1, 5'd9, 32'h99);
        look();
        check("t5_grant", 64'(bus.req_ready), 64'b010);
        tick();
        bus.req_valid   = '0;
        bus.sb_set      = 1'b1;
        bus.sb_set_addr = 5'd9;
        look();
        check("t5_wen", 64'(bus.rf_wen), 64'd1);
        check("t5_waddr", 64'(bus.rf_waddr), 64'd9);
        check("t5_haz_same", 64'(bus.hazard), 64'd1);
        tick();
        bus.sb_set = 1'b0;
        set_req(1, 1'b1, 5'd9, 32'h9A);
        look();
        check("t5_haz_kept", 64'(bus.hazard), 64'd1);
        tick();
        bus.req_valid = '0;
        look();
        check("t5_wen2", 64'(bus.rf_wen), 64'd1);
        check("t5_haz_pending", 64'(bus.hazard), 64'd1);
        tick();
        look();
        check("t5_haz_clear", 64'(bus.hazard), 64'd0);
        tick();

        // 6: unreserved write to x12 raises sticky sb_err
        bus.chk_rs2 = 5'd0;
        set_req(0, 1'b1, 5'd12, 32'h12);
        look();
        tick();
        bus.req_valid = '0;
        look();
        check("t6_wen", 64'(bus.rf_wen), 64'd1);
        check("t6_waddr", 64'(bus.rf_waddr), 64'd12);
        check("t6_err_before", 64'(bus.sb_err), 64'd0);
        tick();
        look();
        check("t6_err", 64'(bus.sb_err), 64'd1);
        tick();
        tick();
        tick();
        look();
        check("t6_err_sticky", 64'(bus.sb_err), 64'd1);
        tick();

        // Reset in the middle of traffic
        bus.sb_set      = 1'b1;
        bus.sb_set_addr = 5'd4;
        bus.chk_rs1     = 5'd4;
        set_req(0, 1'b1, 5'd4, 32'h44);
        look();
        tick();
        bus.sb_set = 1'b0;
        rst        = 1'b1;
        look();
        check("mr_ready", 64'(bus.req_ready), 64'd0);
        check("mr_inflight_wen", 64'(bus.rf_wen), 64'd1);
        check("mr_haz_before", 64'(bus.hazard), 64'd1);
        tick();
        look();
        check("mr_wen", 64'(bus.rf_wen), 64'd0);
        check("mr_waddr", 64'(bus.rf_waddr), 64'd0);
        check("mr_wdata", 64'(bus.rf_wdata), 64'd0);
        check("mr_err", 64'(bus.sb_err), 64'd0);
        check("mr_hazard", 64'(bus.hazard), 64'd0);
        tick();
        rst           = 1'b0;
        bus.req_valid = '0;
        look();
        tick();
        look();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
